// File: rtl/sipo_word_loader_pkg.sv
// Shared constants and types for the serial-to-parallel word loader.
`ifndef SIPO_CNT_W
`define SIPO_CNT_W(w) ($clog2(w))
`endif

package sipo_word_loader_pkg;

  // Default word width: matches the 4-bit enable register this block feeds.
  localparam int DEFAULT_WIDTH = 4;

  // Bit-order encodings for the MSB_FIRST parameter.
  localparam bit MSB_FIRST_EN = 1'b1;
  localparam bit LSB_FIRST_EN = 1'b0;

  // Control state, decoded from (pend, bit_cnt).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PEND  = 2'd2
  } state_e;

endpackage

// File: rtl/sipo_word_loader_shift_reg.sv
// Serial shift register: shifts one bit per enable, or restarts with a single bit.
module sipo_shift_reg
  import sipo_word_loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_EN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             clear_load,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fresh;

  // Bit order only changes which end the new bit enters from.
  generate
    if (MSB_FIRST == MSB_FIRST_EN) begin : g_msb
      assign shifted = {q[WIDTH-2:0], bit_in};
      assign fresh   = {{(WIDTH-1){1'b0}}, bit_in};
    end else begin : g_lsb
      assign shifted = {bit_in, q[WIDTH-1:1]};
      assign fresh   = {bit_in, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // Restart wins over a normal shift so a resync discards all older bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear_load) begin
      q <= fresh;
    end else if (shift_en) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/sipo_word_loader.sv
// Serial-to-parallel word loader: assembles WIDTH-bit words from a bit stream
// and strobes each finished word into a downstream enable register.
module sipo_word_loader
  import sipo_word_loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_EN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             serial_start,
  output logic             serial_ready,
  input  logic             hold,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             frame_err
);

  localparam int CNT_W = `SIPO_CNT_W(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_next;
  logic             pend;
  logic             pend_next;
  logic [WIDTH-1:0] data_next;
  logic             frame_err_next;
  logic             clear_load;
  logic             acc;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word_next;
  state_e           state;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .reset      (reset),
    .shift_en   (acc),
    .clear_load (clear_load),
    .bit_in     (serial_in),
    .q          (shift_q)
  );

  // The completed word must include the bit arriving on the completing edge,
  // so form it here rather than waiting a cycle for the shift register.
  generate
    if (MSB_FIRST == MSB_FIRST_EN) begin : g_word_msb
      assign word_next = {shift_q[WIDTH-2:0], serial_in};
    end else begin : g_word_lsb
      assign word_next = {serial_in, shift_q[WIDTH-1:1]};
    end
  endgenerate

  assign acc = serial_valid & serial_ready;

  // Control state is fully described by pend and bit_cnt.
  always_comb begin
    if (pend) begin
      state = ST_PEND;
    end else if (bit_cnt != '0) begin
      state = ST_SHIFT;
    end else begin
      state = ST_IDLE;
    end
  end

  // State register: counter, pending flag, output word and error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      pend      <= 1'b0;
      data_out  <= '0;
      frame_err <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_next;
      pend      <= pend_next;
      data_out  <= data_next;
      frame_err <= frame_err_next;
    end
  end

  // Next-state logic: a completing word sets pend after the load clears it,
  // so a release and a new completion on the same edge leave pend high.
  always_comb begin
    bit_cnt_next   = bit_cnt;
    pend_next      = pend;
    data_next      = data_out;
    frame_err_next = 1'b0;
    clear_load     = 1'b0;
    if (load) begin
      pend_next = 1'b0;
    end
    if (acc) begin
      if (serial_start) begin
        bit_cnt_next   = ONE;
        clear_load     = 1'b1;
        frame_err_next = (bit_cnt != '0);
      end else if (bit_cnt == LAST_BIT) begin
        bit_cnt_next = '0;
        pend_next    = 1'b1;
        data_next    = word_next;
      end else begin
        bit_cnt_next = bit_cnt + ONE;
      end
    end
  end

  // Handshake outputs: bits stall only while a word waits on hold.
  always_comb begin
    serial_ready = ~reset & ((state != ST_PEND) | ~hold);
    load         = ~reset & (state == ST_PEND) & ~hold;
  end

endmodule
